// File: rtl/uart_echo_tester_pkg.sv
// Shared types and character constants for the serial echo tester.
// ECHO_TEST_BS_EN adds the backspace stimulus as the final index.
package echo_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  localparam logic [7:0] CHR_BS      = 8'h08;
  localparam logic [7:0] CHR_LF      = 8'h0A;
  localparam logic [7:0] CHR_CR      = 8'h0D;
  localparam logic [7:0] CHR_SP      = 8'h20;
  localparam logic [7:0] PRINT_FIRST = 8'h20;
  localparam logic [7:0] PRINT_LAST  = 8'h7E;

  localparam logic [6:0] IDX_PRINT_LAST = 7'd94;
  localparam logic [6:0] IDX_CR         = 7'd95;
  localparam logic [6:0] ERR_IDX_NONE   = 7'h7F;
`ifdef ECHO_TEST_BS_EN
  localparam logic [6:0] IDX_BS   = 7'd96;
  localparam logic [6:0] LAST_IDX = IDX_BS;
`else
  localparam logic [6:0] LAST_IDX = IDX_CR;
`endif

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

endpackage

// File: rtl/uart_echo_tester_if.sv
// Byte-level link between the tester and its UART transmitter/receiver pair.
interface uart_echo_tester_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, output tx_start,
                  input tx_busy, input rx_data, input rx_valid);
  modport slave  (input tx_data, input tx_start,
                  output tx_busy, output rx_data, output rx_valid);
endinterface

// File: rtl/uart_echo_tester_expect_gen.sv
// Maps stimulus index k and response position j to the stimulus byte,
// the expected echo byte and the response length n(k). ECHO_TEST_BS_EN adds BS.
module echo_expect_gen
  import echo_test_pkg::*;
(
  input  logic [6:0] i_k,
  input  logic [1:0] i_j,
  output logic [7:0] o_stim,
  output logic [7:0] o_exp,
  output logic [1:0] o_n
);

  // Stimulus / expectation table
  always_comb begin
    o_stim = 8'h00;
    o_exp  = 8'h00;
    o_n    = 2'd1;
    if (i_k <= IDX_PRINT_LAST) begin
      o_stim = PRINT_FIRST + {1'b0, i_k};
      if (is_upper(o_stim)) begin
        o_exp = o_stim + 8'h20;
      end else if (is_lower(o_stim)) begin
        o_exp = o_stim - 8'h20;
      end else begin
        o_exp = o_stim;
      end
    end else if (i_k == IDX_CR) begin
      o_stim = CHR_CR;
      o_n    = 2'd2;
      o_exp  = (i_j == 2'd0) ? CHR_CR : CHR_LF;
`ifdef ECHO_TEST_BS_EN
    end else if (i_k == IDX_BS) begin
      o_stim = CHR_BS;
      o_n    = 2'd3;
      o_exp  = (i_j == 2'd1) ? CHR_SP : CHR_BS;
`endif
    end else begin
      o_stim = 8'h00;
      o_exp  = 8'h00;
      o_n    = 2'd1;
    end
  end

endmodule

// File: rtl/uart_echo_tester.sv
// Echo-protocol initiator: sends the fixed stimulus sequence and checks echoes.
// Build macro ECHO_TEST_BS_EN appends the backspace stimulus.
module uart_echo_tester
  import echo_test_pkg::*;
#(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  uart_echo_tester_if.master          u_if,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic [7:0]                  o_err_count,
  output logic                        o_timeout,
  output logic [6:0]                  o_first_err_idx
);

  localparam longint TO_CYCLES =
    (longint'(TIMEOUT_BYTES) * 64'sd10 * longint'(CLK_FREQ)) / longint'(BAUD);
  localparam int TO_W = $clog2(TO_CYCLES + 64'sd1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [6:0]        r_k;
  logic [1:0]        r_j;
  logic              r_tx_seen;
  logic [TO_W-1:0]   r_to_cnt;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [7:0]        r_err_count;
  logic              r_timeout;
  logic [6:0]        r_first_err_idx;

  logic [7:0]        w_stim;
  logic [7:0]        w_exp;
  logic [1:0]        w_n;
  logic              w_start_run;
  logic              w_load_tx;
  logic              w_issue;
  logic              w_in_wait;
  logic              w_j_done;
  logic              w_leave;
  logic              w_expire;
  logic              w_err_ev;
  logic [7:0]        w_err_cnt_nxt;

  echo_expect_gen u_expect_gen (
    .i_k    (r_k),
    .i_j    (r_j),
    .o_stim (w_stim),
    .o_exp  (w_exp),
    .o_n    (w_n)
  );

  assign w_j_done = (r_j == w_n);
  assign w_leave  = w_in_wait & w_j_done & r_tx_seen & ~u_if.tx_busy;
  // A received byte always beats a coincident expiry and restarts the counter.
  assign w_expire = w_in_wait & ~u_if.rx_valid & (r_to_cnt == TO_LIMIT) & ~w_leave;
  assign w_err_ev = (w_in_wait & u_if.rx_valid & (w_j_done | (u_if.rx_data != w_exp)))
                  | w_expire;
  assign w_err_cnt_nxt = (w_err_ev && (r_err_count != 8'hFF)) ? (r_err_count + 8'd1)
                                                               : r_err_count;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      w_state_nxt = i_start ? ST_SEND : ST_IDLE;
      ST_SEND:      w_state_nxt = u_if.tx_busy ? ST_SEND : ST_ISSUE;
      ST_ISSUE:     w_state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (w_leave) begin
          w_state_nxt = (r_k == LAST_IDX) ? ST_FINISH : ST_SEND;
        end else begin
          w_state_nxt = ST_WAIT_RESP;
        end
      end
      ST_FINISH:    w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control decode
  always_comb begin
    w_start_run = 1'b0;
    w_load_tx   = 1'b0;
    w_issue     = 1'b0;
    w_in_wait   = 1'b0;
    case (r_state)
      ST_IDLE:      w_start_run = i_start;
      ST_SEND:      w_load_tx   = ~u_if.tx_busy;
      ST_ISSUE:     w_issue     = 1'b1;
      ST_WAIT_RESP: w_in_wait   = 1'b1;
      default:      w_start_run = 1'b0;
    endcase
  end

  // Counters, registered outputs and error bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k             <= 7'd0;
      r_j             <= 2'd0;
      r_tx_seen       <= 1'b0;
      r_to_cnt        <= '0;
      r_tx_data       <= 8'h00;
      r_tx_start      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= 8'h00;
      r_timeout       <= 1'b0;
      r_first_err_idx <= ERR_IDX_NONE;
    end else begin
      r_tx_start <= w_load_tx;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_FINISH);
      if (w_start_run) begin
        r_k             <= 7'd0;
        r_err_count     <= 8'h00;
        r_timeout       <= 1'b0;
        r_pass          <= 1'b0;
        r_first_err_idx <= ERR_IDX_NONE;
      end else begin
        r_err_count <= w_err_cnt_nxt;
        if (w_err_ev && (r_first_err_idx == ERR_IDX_NONE)) begin
          r_first_err_idx <= r_k;
        end
        if (w_state_nxt == ST_FINISH) begin
          r_pass <= (w_err_cnt_nxt == 8'h00);
        end
        if (w_leave) begin
          r_k <= r_k + 7'd1;
        end
      end
      if (w_load_tx) begin
        r_tx_data <= w_stim;
      end
      if (w_issue) begin
        r_j       <= 2'd0;
        r_tx_seen <= 1'b0;
        r_to_cnt  <= '0;
      end else if (w_in_wait) begin
        if (u_if.tx_busy) begin
          r_tx_seen <= 1'b1;
        end
        if (u_if.rx_valid) begin
          r_to_cnt <= '0;
          if (!w_j_done) begin
            r_j <= r_j + 2'd1;
          end
        end else if (w_expire) begin
          // Give up on this stimulus; a transmitter that never went busy counts as sent.
          r_to_cnt  <= '0;
          r_j       <= w_n;
          r_tx_seen <= 1'b1;
          r_timeout <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign u_if.tx_data    = r_tx_data;
  assign u_if.tx_start   = r_tx_start;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_count     = r_err_count;
  assign o_timeout       = r_timeout;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: doc/uart_echo_tester.md
# uart_echo_tester

Initiator side of the serial echo protocol: drives a fixed stimulus sequence into a byte-level UART transmitter and checks the echoed bytes returned through a UART receiver. The expected response rules are:
- letters are returned with swapped case;
- CR is returned as CR LF;
- BS is returned as BS SP BS.

The tester sits between `uart_tx`/`uart_rx` instances in a board-to-board or simulation loopback. It reports pass/fail, an error count and timeouts.

## Interface
- `CLK_FREQ`, 25_000_000, clock frequency in Hz
- `BAUD`, 115200, line rate; byte time = 10*CLK_FREQ/BAUD cycles (2170 at defaults)
- `TIMEOUT_BYTES`, 4, response timeout per stimulus, in byte times (8680 cycles at defaults)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a run; ignored while `busy`
- `tx_data`  out  8  byte to transmit
- `tx_start`  out  1  one-cycle transmit request
- `tx_busy`  in  1  transmitter busy
- `rx_data`  in  8  received byte, valid with `rx_valid`
- `rx_valid`  in  1  one-cycle received-byte strobe
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `pass`  out  1  run finished with `err_count`==0; held until next `start`
- `err_count`  out  8  mismatches + unexpected bytes + timeouts, saturating at 255
- `timeout`  out  1  sticky; at least one timeout occurred this run
- `first_err_idx`  out  7  stimulus index of the first error; 7'h7F if none

## Operation
- **Stimulus index k:**
  - k = 0..94: byte 0x20+k
  - k = 95: 0x0D
  - k = 96: 0x08
- **Expected response per stimulus:**
  - 0x41–0x5A: one byte, +0x20
  - 0x61–0x7A: one byte, −0x20
  - other printable bytes: one byte, unchanged
  - 0x0D: 0x0D, 0x0A
  - 0x08: 0x08, 0x20, 0x08
- **Totals:** 97 sends, 100 expected bytes.
- **FSM states:** IDLE, SEND, ISSUE, WAIT_RESP, FINISH.
  - IDLE: on `start`, clear `err_count`, `timeout` and `pass`; set `first_err_idx`=7F; k=0; go to SEND.
  - SEND: wait for `tx_busy`=0; load `tx_data`; go to ISSUE.
  - ISSUE: `tx_start`=1 for exactly one cycle; clear expected-byte index j, `tx_seen` and the timeout counter; go to WAIT_RESP.
  - WAIT_RESP: if `tx_busy` is seen high, set `tx_seen`.
    - On each `rx_valid`: if j < n(k), compare with expected byte j; on mismatch, count an error. Then j++.
    - On `rx_valid` with j == n(k): count an unexpected-byte error.
    - Leave when j == n(k) and `tx_seen` and `tx_busy`=0: k++. If k has passed the last index, go to FINISH; otherwise go to SEND.
  - FINISH: pulse `done`; set `pass` if `err_count`==0; go to IDLE.
- **Timeout:**
  - The counter restarts at ISSUE and at every `rx_valid`.
  - On expiry in WAIT_RESP, count one error, set `timeout`, force j = n(k), and continue.
  - If `tx_busy` never rose, the byte is treated as sent.
- **Error recording:** every error increments `err_count` (saturating) and latches k into `first_err_idx` if that field is still 7F.
- `rx_valid` in IDLE or FINISH is ignored.

## Timing
- **Reset values:**
  - `tx_data`=0, `tx_start`=0, `busy`=0, `done`=0, `pass`=0
  - `err_count`=0, `timeout`=0, `first_err_idx`=7F
  - FSM in IDLE
- `tx_start` rises 2 cycles after the `start` pulse, provided `tx_busy`=0.
- `busy`=1 from the cycle after `start` through the FINISH cycle.
- `rst` mid-run aborts the run within one cycle: no further `tx_start`, outputs take their reset values. In-flight UART bytes are not tracked.
- `rx_valid` and timeout expiry in the same cycle: `rx_valid` wins, and the counter restarts.
- `start` coincident with `rst`: ignored.
- Timeout counter width: $clog2(TIMEOUT_BYTES*10*CLK_FREQ/BAUD + 1).

## Configuration
- `ECHO_TEST_BS_EN` defined: stimulus k=96 (BS) is included; 97 sends, 100 expected bytes.
- `ECHO_TEST_BS_EN` undefined: the run ends after k=95; 96 sends, 97 expected bytes. The BS expectation logic is compiled out.

## Structure
- Package `echo_test_pkg`:
  - FSM state enum
  - constants CHR_BS=0x08, CHR_LF=0x0A, CHR_CR=0x0D, CHR_SP=0x20, PRINT_FIRST=0x20, PRINT_LAST=0x7E, LAST_IDX
- Sub-module `echo_expect_gen`: combinational map from (k, j) to stimulus byte, expected byte and n(k).
- FSM, counters and error bookkeeping live in `uart_echo_tester`.

## Test plan
- **Correct behavioural responder, default parameters:** `start` → 97 `tx_start` pulses, `done` once, `pass`=1, `err_count`=0, `first_err_idx`=7F.
- **Responder echoes 'a' (0x61) unswapped:** `err_count`=1, `pass`=0, `first_err_idx`=0x41.
- **Responder omits the LF after CR:** `timeout`=1, `err_count`=1, `first_err_idx`=0x5F; the run still completes and `done` pulses.
- **Responder returns 'Z' twice (0x7A, 0x7A):** the unexpected second byte gives `err_count`=1 and `first_err_idx`=0x3A.
- **`rst` after the 40th `tx_start`:** all outputs return to reset values the next cycle and no further `tx_start` occurs; a following `start` gives `pass`=1.
- **`ECHO_TEST_BS_EN` undefined:** 96 sends, 97 responses checked, `pass`=1.
